issue_stage: RTL



---
 rtl/issue_pkg.sv | 75 +++++++
 rtl/issue_stage_if.sv | 44 ++++
 rtl/issue_stage_scoreboard.sv | 36 +++
 rtl/issue_stage.sv | 109 ++++++++++
 4 files changed

// File: rtl/issue_pkg.sv
// rtl/issue_pkg.sv - Shared opcode constants, FU select encoding and bundle types for the issue stage
package issue_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    FU_ALU = 2'd0,
    FU_MUL = 2'd1,
    FU_MEM = 2'd2
  } fu_sel_e;

  typedef struct packed {
    logic        selalushift;
    logic        selimregb;
    logic [2:0]  aluop;
    logic        unsig;
    logic [1:0]  shiftop;
    logic        readmem;
    logic        writemem;
    logic [31:0] imedext;
    logic        selwsource;
    logic [4:0]  regdest;
    logic        writereg;
    logic        writeov;
    logic        selregdest;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  addra;
    logic [4:0]  addrb;
  } id_bundle_t;

  typedef struct packed {
    logic [2:0] aluop;
    logic       unsig;
    logic [1:0] shiftop;
    logic       selalushift;
    logic       readmem;
    logic       writemem;
    logic       selwsource;
    logic       writeov;
    logic [2:0] funct3;
    logic [4:0] regdest;
    logic       writereg;
  } fu_ctrl_t;

  function automatic fu_sel_e fu_select(input logic [6:0] opcode, input logic [6:0] funct7);
    if (opcode == OP_R && funct7 == FUNCT7_MULDIV) return FU_MUL;
    if (opcode == OP_LOAD || opcode == OP_STORE) return FU_MEM;
    return FU_ALU;
  endfunction

  // U-type and JAL carry no rs1 field; only R, store and branch read rs2.
  function automatic logic uses_rs1(input logic [6:0] opcode);
    return !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opcode);
    return (opcode == OP_R || opcode == OP_STORE || opcode == OP_BRANCH);
  endfunction

  function automatic logic is_alu_imm(input logic [6:0] opcode);
    return (opcode == OP_IMM);
  endfunction

endpackage

// File: rtl/issue_stage_if.sv
// rtl/issue_stage_if.sv - Decode bundle, ARF read, FU dispatch, writeback and counter signals of the issue stage
interface issue_stage_if;
  import issue_pkg::*;

  id_bundle_t  id_iss;
  logic        iss_stall;
  logic        id_stall;
  logic [4:0]  iss_reg_addra;
  logic [4:0]  iss_reg_addrb;
  logic [31:0] reg_iss_dataa;
  logic [31:0] reg_iss_datab;
  logic        iss_alu_valid;
  logic        iss_mul_valid;
  logic        iss_mem_valid;
  logic        alu_ready;
  logic        mul_ready;
  logic        mem_ready;
  logic [31:0] iss_fu_opa;
  logic [31:0] iss_fu_opb;
  logic [31:0] iss_fu_stdata;
  fu_ctrl_t    iss_fu_ctrl;
  logic        wb_a_valid;
  logic [4:0]  wb_a_addr;
  logic        wb_b_valid;
  logic [4:0]  wb_b_addr;
  logic [31:0] perf_issued;
  logic [31:0] perf_hazard_cycles;

  modport slave (
    input  id_iss, reg_iss_dataa, reg_iss_datab, alu_ready, mul_ready, mem_ready,
           wb_a_valid, wb_a_addr, wb_b_valid, wb_b_addr,
    output iss_stall, id_stall, iss_reg_addra, iss_reg_addrb, iss_alu_valid, iss_mul_valid,
           iss_mem_valid, iss_fu_opa, iss_fu_opb, iss_fu_stdata, iss_fu_ctrl,
           perf_issued, perf_hazard_cycles
  );

  modport master (
    output id_iss, reg_iss_dataa, reg_iss_datab, alu_ready, mul_ready, mem_ready,
           wb_a_valid, wb_a_addr, wb_b_valid, wb_b_addr,
    input  iss_stall, id_stall, iss_reg_addra, iss_reg_addrb, iss_alu_valid, iss_mul_valid,
           iss_mem_valid, iss_fu_opa, iss_fu_opb, iss_fu_stdata, iss_fu_ctrl,
           perf_issued, perf_hazard_cycles
  );
endinterface

// File: rtl/issue_stage_scoreboard.sv
// rtl/issue_stage_scoreboard.sv - 32-entry register busy vector: one set, two clears, three read ports
module scoreboard (
  input  logic       clock,
  input  logic       reset,
  input  logic       set_en_i,
  input  logic [4:0] set_addr_i,
  input  logic       clr_a_en_i,
  input  logic [4:0] clr_a_addr_i,
  input  logic       clr_b_en_i,
  input  logic [4:0] clr_b_addr_i,
  input  logic [4:0] rs1_addr_i,
  input  logic [4:0] rs2_addr_i,
  input  logic [4:0] rd_addr_i,
  output logic       rs1_busy_o,
  output logic       rs2_busy_o,
  output logic       rd_busy_o
);
  logic [31:0] busy_q, busy_d;

  // x0 is never set, so its bit stays 0 and reads of x0 never report busy.
  always_comb begin
    busy_d = busy_q;
    if (clr_a_en_i && clr_a_addr_i != 5'd0) busy_d[clr_a_addr_i] = 1'b0;
    if (clr_b_en_i && clr_b_addr_i != 5'd0) busy_d[clr_b_addr_i] = 1'b0;
    if (set_en_i && set_addr_i != 5'd0) busy_d[set_addr_i] = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign rs1_busy_o = busy_q[rs1_addr_i];
  assign rs2_busy_o = busy_q[rs2_addr_i];
  assign rd_busy_o  = busy_q[rd_addr_i];
endmodule

// File: rtl/issue_stage.sv
// rtl/issue_stage.sv - In-order issue slot: scoreboard RAW/WAW check, operand read, valid/ready dispatch to ALU/MUL/MEM
module issue_stage
  import issue_pkg::*;
(
  input logic          clock,
  input logic          reset,
  issue_stage_if.slave bus
);
  id_bundle_t  slot_q, slot_d;
  logic [31:0] perf_issued_q, perf_issued_d;
  logic [31:0] perf_hazard_q, perf_hazard_d;
  logic        slot_valid, rs1_busy, rs2_busy, rd_busy;
  logic        raw, waw, dispatch_ok, unit_ready, fire, iss_stall, sb_set;
  fu_sel_e     fu_sel;
  fu_ctrl_t    ctrl;
  logic        unused_slot;

  assign slot_valid  = (slot_q.opcode != 7'd0);
  assign fu_sel      = fu_select(slot_q.opcode, slot_q.funct7);
  assign unused_slot = slot_q.selregdest ^ is_alu_imm(slot_q.opcode);

  scoreboard u_scoreboard (
    .clock        (clock),
    .reset        (reset),
    .set_en_i     (sb_set),
    .set_addr_i   (slot_q.regdest),
    .clr_a_en_i   (bus.wb_a_valid),
    .clr_a_addr_i (bus.wb_a_addr),
    .clr_b_en_i   (bus.wb_b_valid),
    .clr_b_addr_i (bus.wb_b_addr),
    .rs1_addr_i   (slot_q.addra),
    .rs2_addr_i   (slot_q.addrb),
    .rd_addr_i    (slot_q.regdest),
    .rs1_busy_o   (rs1_busy),
    .rs2_busy_o   (rs2_busy),
    .rd_busy_o    (rd_busy)
  );

  // Registered scoreboard only: a writeback at edge M unblocks a consumer in cycle M+1.
  assign raw = (uses_rs1(slot_q.opcode) && slot_q.addra != 5'd0 && rs1_busy) ||
               (uses_rs2(slot_q.opcode) && slot_q.addrb != 5'd0 && rs2_busy);
  assign waw = slot_q.writereg && (slot_q.regdest != 5'd0) && rd_busy;
  assign dispatch_ok = slot_valid && !raw && !waw;

  always_comb begin
    unit_ready = 1'b0;
    case (fu_sel)
      FU_ALU:  unit_ready = bus.alu_ready;
      FU_MUL:  unit_ready = bus.mul_ready;
      FU_MEM:  unit_ready = bus.mem_ready;
      default: unit_ready = 1'b0;
    endcase
  end

  assign fire      = dispatch_ok && unit_ready;
  assign iss_stall = slot_valid && !fire;
  assign sb_set    = fire && slot_q.writereg && (slot_q.regdest != 5'd0);

  assign bus.iss_stall     = iss_stall;
  assign bus.id_stall      = iss_stall;
  assign bus.iss_alu_valid = dispatch_ok && (fu_sel == FU_ALU);
  assign bus.iss_mul_valid = dispatch_ok && (fu_sel == FU_MUL);
  assign bus.iss_mem_valid = dispatch_ok && (fu_sel == FU_MEM);
  assign bus.iss_reg_addra = slot_q.addra;
  assign bus.iss_reg_addrb = slot_q.addrb;

  // Payload is forced to zero while the slot is empty so idle outputs stay quiet.
  assign bus.iss_fu_opa    = slot_valid ? bus.reg_iss_dataa : 32'd0;
  assign bus.iss_fu_opb    = !slot_valid     ? 32'd0 :
                             slot_q.selimregb ? slot_q.imedext : bus.reg_iss_datab;
  assign bus.iss_fu_stdata = slot_valid ? bus.reg_iss_datab : 32'd0;

  always_comb begin
    ctrl = '0;
    if (slot_valid) begin
      ctrl.aluop       = slot_q.aluop;
      ctrl.unsig       = slot_q.unsig;
      ctrl.shiftop     = slot_q.shiftop;
      ctrl.selalushift = slot_q.selalushift;
      ctrl.readmem     = slot_q.readmem;
      ctrl.writemem    = slot_q.writemem;
      ctrl.selwsource  = slot_q.selwsource;
      ctrl.writeov     = slot_q.writeov;
      ctrl.funct3      = slot_q.funct3;
      ctrl.regdest     = slot_q.regdest;
      ctrl.writereg    = slot_q.writereg;
    end
  end
  assign bus.iss_fu_ctrl = ctrl;

  assign slot_d        = iss_stall ? slot_q : bus.id_iss;
  assign perf_issued_d = perf_issued_q + {31'd0, fire};
  assign perf_hazard_d = perf_hazard_q + {31'd0, slot_valid && (raw || waw)};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      slot_q        <= '0;
      perf_issued_q <= '0;
      perf_hazard_q <= '0;
    end else begin
      slot_q        <= slot_d;
      perf_issued_q <= perf_issued_d;
      perf_hazard_q <= perf_hazard_d;
    end
  end

  assign bus.perf_issued        = perf_issued_q;
  assign bus.perf_hazard_cycles = perf_hazard_q;
endmodule
